// File: rtl/bin_maxpool2x2.sv
// 2x2 stride-2 OR pooling of binary feature maps, SRAM to SRAM.
// Walks header-delimited images until an invalid header, one pooled row per three cycles.
module bin_maxpool2x2 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR_HDR,
        S_RD_A,
        S_RD_B,
        S_WR_ROW,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]        p_q, p_d;
    logic [2:0]        row_idx_q, row_idx_d;
    logic [DATA_W-1:0] row_a_q, row_a_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;

    logic [4:0]        hdr_m;
    logic              hdr_valid;
    logic [DATA_W-1:0] pooled;

    assign hdr_m     = sram_dut_read_data[4:0];
    assign hdr_valid = (hdr_m == 5'd8) || (hdr_m == 5'd10) || (hdr_m == 5'd14);

    // Row a is held in row_a_q; row b is the word arriving from the SRAM this cycle.
    always_comb begin
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (j < int'(p_q)) begin
                pooled[j] = row_a_q[2*j] | row_a_q[2*j+1]
                          | sram_dut_read_data[2*j] | sram_dut_read_data[2*j+1];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here first so no path can infer a latch.
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        p_d       = p_q;
        row_idx_d = row_idx_q;
        row_a_d   = row_a_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dut_run) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (!hdr_valid) begin
                    state_d = S_DONE;
                end else begin
                    p_d       = hdr_m[3:1];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    row_idx_d = '0;
                    state_d   = S_WR_HDR;
                end
            end
            S_WR_HDR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_ptr_q;
                wr_data_d = DATA_W'(p_q);
                wr_ptr_d  = wr_ptr_q + 1'b1;
                state_d   = S_RD_A;
            end
            S_RD_A: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                row_a_d  = sram_dut_read_data;
                rd_ptr_d = rd_ptr_q + 1'b1;
                state_d  = S_WR_ROW;
            end
            S_WR_ROW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_ptr_q;
                wr_data_d = pooled;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (row_idx_q == p_q - 3'd1) begin
                    state_d = S_FETCH;
                end else begin
                    row_idx_d = row_idx_q + 3'd1;
                    state_d   = S_RD_A;
                end
            end
            S_DONE: begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The read address register is loaded on entry so the state that reads sees it on the bus.
        if (state_d inside {S_FETCH, S_RD_A, S_RD_B}) begin
            rd_addr_d = rd_ptr_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset_b) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            p_q       <= '0;
            row_idx_q <= '0;
            row_a_q   <= '0;
            busy_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            p_q       <= p_d;
            row_idx_q <= row_idx_d;
            row_a_q   <= row_a_d;
            busy_q    <= busy_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = wr_en_q;

endmodule

// File: tb/tb_bin_maxpool2x2.sv
// Self-checking bench for bin_maxpool2x2: SRAM models, a job-level pooling model,
// and a per-cycle write checker.
module tb_bin_maxpool2x2;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        dut_run = 1'b0;
    logic        dut_busy;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        we;

    bin_maxpool2x2 #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (rd_addr),
        .sram_dut_read_data     (rd_data),
        .dut_sram_write_address (wr_addr),
        .dut_sram_write_data    (wr_data),
        .dut_sram_write_enable  (we)
    );

    always #5 clk = ~clk;

    logic [15:0] src     [4096];
    logic [15:0] dst     [4096];
    int          dst_gen [4096];
    int          seen_gen[4096];

    always @(posedge clk) begin
        rd_data <= src[rd_addr];
        if (we) begin
            dst[wr_addr]     <= wr_data;
            dst_gen[wr_addr] <= job_id;
        end
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_all[$];
    int  exp_n, exp_busy, exp_term;
    int  n_vec = 0;
    int  n_err = 0;
    int  wr_cnt = 0;
    int  wr_base = 0;
    int  job_id = 0;
    int  sp;
    int  last_busy;
    bit  prev_we = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // OR over the 2x2 pixel window (rows a/b, columns 2j/2j+1) for each output column j < p.
    function automatic logic [15:0] pool_row(input logic [15:0] a, input logic [15:0] b, input int p);
        logic [15:0] r;
        logic [3:0]  win;
        r = '0;
        for (int j = 0; j < p; j++) begin
            win  = {a[2*j], a[2*j+1], b[2*j], b[2*j+1]};
            r[j] = (win != 4'b0);
        end
        return r;
    endfunction

    function automatic void build_model();
        int rp, wp, m, p;
        logic [15:0] h;
        exp_all.delete();
        rp = 0;
        wp = 0;
        exp_busy = 3;
        while (1) begin
            h = src[rp[11:0]];
            m = int'(h[4:0]);
            if (!(m == 8 || m == 10 || m == 14)) break;
            p = m / 2;
            exp_all.push_back('{wp, p});
            wp++;
            for (int i = 0; i < p; i++) begin
                exp_all.push_back('{wp, int'(pool_row(src[(rp + 1 + 2*i) % 4096],
                                                      src[(rp + 2 + 2*i) % 4096], p))});
                wp++;
            end
            rp += 1 + m;
            exp_busy += 3 + 3 * p;
        end
        exp_term = rp;
        exp_n = exp_all.size();
    endfunction

    // Per-cycle checker: every write strobe must match the next word the model predicts.
    always @(negedge clk) begin
        int k;
        if (!reset_b) begin
            if (dut_busy) seen_gen[rd_addr] = job_id;
            if (we) begin
                k = wr_cnt - wr_base;
                check("we_gap", int'(prev_we), 0);
                if (k < exp_n) begin
                    check("wr_addr", int'(wr_addr), exp_all[k].addr);
                    check("wr_data", int'(wr_data), exp_all[k].data);
                end else begin
                    check("write_overrun", k, exp_n - 1);
                end
                wr_cnt++;
            end
        end
        prev_we = we;
    end

    task automatic clear_src();
        foreach (src[i]) src[i] = 16'h0;
        sp = 0;
    endtask

    task automatic put(input logic [15:0] w);
        src[sp] = w;
        sp++;
    endtask

    task automatic run_job(input string tag, input bit spurious);
        int bc, guard, nseen, maxa;
        build_model();
        job_id++;
        wr_base = wr_cnt;
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        bc = 0;
        guard = 0;
        while (dut_busy && guard < 5000) begin
            bc++;
            guard++;
            dut_run = spurious && (bc == 6);
            @(negedge clk);
        end
        dut_run = 1'b0;
        last_busy = bc;
        check({tag, "_busy_cycles"}, bc, exp_busy);
        check({tag, "_write_count"}, wr_cnt - wr_base, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            check({tag, "_dst_word"}, int'(dst[exp_all[k].addr]), exp_all[k].data);
        end
        nseen = 0;
        maxa = -1;
        for (int a = 0; a < 4096; a++) begin
            if (seen_gen[a] == job_id) begin
                nseen++;
                maxa = a;
            end
        end
        check({tag, "_rd_last_addr"}, maxa, exp_term);
        check({tag, "_rd_addr_count"}, nseen, exp_term + 1);
    endtask

    initial begin
        int s, guard, nimg, m;
        logic [15:0] term;

        foreach (dst_gen[i]) dst_gen[i] = 0;
        foreach (seen_gen[i]) seen_gen[i] = 0;
        foreach (dst[i]) dst[i] = 16'h0;
        clear_src();

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_busy", int'(dut_busy), 0);
        check("rst_we", int'(we), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        reset_b = 1'b0;
        @(negedge clk);

        // Single 8-wide image.
        clear_src();
        put(16'h0008); put(16'h0003); put(16'h0000); put(16'h0080); put(16'h0040);
        repeat (4) put(16'h0000);
        put(16'h00FF);
        run_job("t1", 1'b0);
        check("t1_lit_busy", last_busy, 18);
        check("t1_lit_writes", wr_cnt - wr_base, 5);
        check("t1_lit_d0", int'(dst[0]), 16'h0004);
        check("t1_lit_d1", int'(dst[1]), 16'h0001);
        check("t1_lit_d2", int'(dst[2]), 16'h0008);
        check("t1_lit_d3", int'(dst[3]), 16'h0000);
        check("t1_lit_d4", int'(dst[4]), 16'h0000);

        // 14-wide all ones.
        clear_src();
        put(16'h000E);
        repeat (14) put(16'h3FFF);
        put(16'h00FF);
        run_job("t2", 1'b0);
        check("t2_lit_hdr", int'(dst[0]), 16'h0007);
        for (int k = 1; k <= 7; k++) check("t2_lit_row", int'(dst[k]), 16'h007F);

        // Back-to-back 10-wide then 8-wide.
        clear_src();
        put(16'h000A);
        repeat (10) put(16'($urandom));
        put(16'h0008);
        repeat (8) put(16'($urandom));
        put(16'h00FF);
        run_job("t3", 1'b0);
        check("t3_lit_hdr2_at6", int'(dst[6]), 16'h0004);
        check("t3_lit_hdr2_read_at11", int'(seen_gen[11] == job_id), 1);

        // Immediate terminator.
        clear_src();
        put(16'h00FF);
        run_job("t4", 1'b0);
        check("t4_lit_busy", last_busy, 3);
        check("t4_lit_writes", wr_cnt - wr_base, 0);

        // Reset mid-job, then rerun.
        clear_src();
        put(16'h000E);
        repeat (14) put(16'($urandom));
        put(16'h00FF);
        build_model();
        job_id++;
        wr_base = wr_cnt;
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        s = 0;
        guard = 0;
        while (s < 2 && guard < 500) begin
            if (we) s++;
            if (s < 2) @(negedge clk);
            guard++;
        end
        check("t5_two_strobes_seen", s, 2);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check("t5_busy", int'(dut_busy), 0);
        check("t5_we", int'(we), 0);
        check("t5_rd_addr", int'(rd_addr), 0);
        check("t5_wr_addr", int'(wr_addr), 0);
        check("t5_wr_data", int'(wr_data), 0);
        check("t5_writes_before_reset", wr_cnt - wr_base, 2);
        @(negedge clk);
        reset_b = 1'b0;
        run_job("t5_rerun", 1'b0);

        // Spurious run mid-image and an M=12 header acting as terminator.
        clear_src();
        put(16'h0008);
        repeat (8) put(16'($urandom));
        put(16'h000C);
        repeat (12) put(16'($urandom));
        put(16'h00FF);
        run_job("t6", 1'b1);
        check("t6_lit_writes", wr_cnt - wr_base, 5);
        check("t6_lit_no_m12_hdr", int'(dst_gen[5] == job_id), 0);

        // Randomized jobs.
        for (int it = 0; it < 20; it++) begin
            clear_src();
            nimg = $urandom_range(1, 3);
            for (int n = 0; n < nimg; n++) begin
                case ($urandom_range(0, 2))
                    0: m = 8;
                    1: m = 10;
                    default: m = 14;
                endcase
                put(16'(m));
                for (int r = 0; r < m; r++) put(16'($urandom));
            end
            case ($urandom_range(0, 3))
                0: term = 16'h00FF;
                1: term = 16'h000C;
                2: term = 16'h0000;
                default: term = 16'h0010;
            endcase
            put(term);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_job("rnd", it[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin_maxpool2x2.md
# bin_maxpool2x2

Downstream stage of the binary XNOR-convolution engine: reads the convolution engine's binary feature maps from a source SRAM, applies 2×2 stride-2 OR (binary max) pooling, and writes the pooled maps to a destination SRAM. Runs one job per `dut_run` pulse, processing a sequence of images until it reads a terminator header. It uses the same run/busy handshake and 12-bit SRAM port conventions as the convolution engine.

## Interface
Parameters:
- `ADDR_W`, 12: SRAM address width.
- `DATA_W`, 16: SRAM data width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_b`  in  1  reset, synchronous, active-high: asserted when 1, sampled on `clk`.
- `dut_run`  in  1  job start; sampled only in IDLE.
- `dut_busy`  out  1  high from the cycle after `dut_run` is accepted until the job ends.
- `dut_sram_read_address`  out  12  source SRAM read address (registered).
- `sram_dut_read_data`  in  16  source data; valid the cycle after the address is driven.
- `dut_sram_write_address`  out  12  destination SRAM write address (registered).
- `dut_sram_write_data`  out  16  destination write data (registered).
- `dut_sram_write_enable`  out  1  destination write strobe (registered), one cycle per word.

## Operation
- Source format, starting at address 0: a header word, then M row words, repeated per image. Header bits[4:0] = M ∈ {8, 10, 14}. Row bit k = pixel column k (bit 0 = column 0). Header 16'h00FF is the terminator.
- A header with any other M value is also treated as a terminator.
- Destination format, starting at address 0: a header word carrying P = M/2 in bits[4:0] (upper bits 0), then P pooled row words per image. No terminator word is written.
- Pooled output row i, bit j (j < P) = a[2j] | a[2j+1] | b[2j] | b[2j+1], where a = source row 2i and b = source row 2i+1. Bits P..15 are 0.
- FSM states:
  - IDLE: busy=0. If `dut_run`=1, clear rd_ptr and wr_ptr → FETCH.
  - FETCH: drive read address rd_ptr → DECODE.
  - DECODE: examine the header. On terminator → DONE. Otherwise latch M, increment rd_ptr, clear row_idx → WR_HDR.
  - WR_HDR: write P at wr_ptr, increment wr_ptr → RD_A.
  - RD_A: drive read address rd_ptr, increment rd_ptr → RD_B.
  - RD_B: capture row a, drive read address rd_ptr, increment rd_ptr → WR_ROW.
  - WR_ROW: combine row a with incoming row b, write at wr_ptr, increment wr_ptr. If row_idx = P−1 → FETCH; otherwise increment row_idx → RD_A.
  - DONE: clear dut_busy and both pointers → IDLE.
- `dut_run` is ignored in every state except IDLE.
- Both pointers wrap modulo 4096. Wrap is not flagged.

## Timing
- Reset value of every output: `dut_busy`=0, `dut_sram_read_address`=0, `dut_sram_write_address`=0, `dut_sram_write_data`=0, `dut_sram_write_enable`=0. FSM returns to IDLE.
- Reset asserted mid-job: on the next edge all outputs take their reset values. No further write is issued, and the job is abandoned.
- Reset takes priority over `dut_run` in the same cycle.
- Cycle 0 = edge where `dut_run` is sampled in IDLE. `dut_busy`=1 from cycle 1.
- Each image takes 3 + 3·P cycles: FETCH, DECODE, WR_HDR, then P × (RD_A, RD_B, WR_ROW).
- The terminator takes 2 cycles (FETCH, DECODE), plus 1 for DONE. `dut_busy` falls on the edge leaving DONE.
- Because outputs are registered, each write strobe, address and data appear together in the cycle after the WR_HDR or WR_ROW state.
- `dut_sram_write_enable` is never high on two consecutive cycles.
- Read-to-use latency is exactly 1 cycle. The block never issues a read and a write of the same SRAM.

## Test plan
- **Single 8-wide image.** Source: [0x0008, 0x0003, 0x0000, 0x0080, 0x0040, 0x0000×4, 0x00FF]. Required: destination [0x0004, 0x0001, 0x0008, 0x0000, 0x0000]. 5 write strobes; `dut_busy` high for 3+12+3 = 18 cycles.
- **14-wide all ones.** Source: header 0x000E, 14 rows of 0x3FFF, terminator. Required: header 0x0007, then 7 words of 0x007F, with upper bits verified 0.
- **Back-to-back images.** Source: a 10-wide image then an 8-wide image, then terminator. Required: second header 0x0004 written at address 6; read of the second header at address 11.
- **Immediate terminator.** Source address 0 = 0x00FF. Required: zero write strobes; `dut_busy` high for exactly 3 cycles.
- **Reset mid-job.** Assert `reset_b`=1 in the cycle after the 2nd write strobe of a 14-wide image. Required: next cycle busy=0, write enable=0, both addresses 0. A subsequent `dut_run` reruns the job from address 0 with identical results.
- **Spurious run / invalid M.** Pulse `dut_run` during an image: output unchanged. A header with M=12 terminates the job with no header written.
